// File: rtl/solver_feeder_if.sv
// Job-stream and result handshakes between a job source and solver_feeder.
// The slave side is the feeder; the master side is the producer/consumer.
interface solver_feeder_if #(
  parameter int LIMB_BITS = 32,
  parameter int ID_BITS   = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [LIMB_BITS-1:0] in_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_BITS-1:0]   res_id;
  logic [15:0]          res_count;
  logic                 res_err;

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_id, res_count, res_err
  );

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_id, res_count, res_err
  );
endinterface

// File: rtl/solver_feeder.sv
// Unpacks header + real/imag limb jobs into solver_control writes,
// kicks the solver and returns one tagged result per job.
module solver_feeder #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int ID_BITS         = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  solver_feeder_if.slave             job,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_ind,
  output logic [LIMB_BITS-1:0]       limb_data,
  output logic                       wr_num_limbs_en,
  output logic                       wr_iter_lim_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic [15:0]                iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [15:0]                iteration_count,
  output logic [15:0]                jobs_done
);
  localparam int LIB = LIMB_INDEX_BITS;

  typedef enum logic [2:0] {
    HDR, LOAD_RE, LOAD_IM, START, WAIT
  } state_t;

  state_t             r_state;
  logic [LIB-1:0]     r_cnt;
  logic [LIB-1:0]     r_n;
  logic [ID_BITS-1:0] r_id;
  logic               r_res_valid;
  logic [ID_BITS-1:0] r_res_id;
  logic [15:0]        r_res_count;
  logic               r_res_err;
  logic [15:0]        r_jobs;

  logic [LIB-1:0]     w_hdr_n;
  logic [15:0]        w_hdr_lim;
  logic [ID_BITS-1:0] w_hdr_id;
  logic               w_n_zero;
  logic               w_in_ready;
  logic               w_acc;
  logic               w_last;
  logic               w_res_hs;

  assign w_hdr_n   = job.in_data[LIB-1:0];
  assign w_hdr_lim = job.in_data[LIB+15:LIB];
  assign w_hdr_id  = job.in_data[LIB+16+ID_BITS-1:LIB+16];
  assign w_n_zero  = (w_hdr_n == '0);
  assign w_last    = (r_cnt == r_n - 1'b1);
  assign w_res_hs  = r_res_valid && job.res_ready;

  // An empty job needs the result slot, so it back-pressures while busy
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      HDR:              w_in_ready = !(w_n_zero && r_res_valid);
      LOAD_RE, LOAD_IM: w_in_ready = 1'b1;
      default:          w_in_ready = 1'b0;
    endcase
    if (!reset) w_in_ready = 1'b0;
  end

  assign w_acc = job.in_valid && w_in_ready;

  assign wr_num_limbs_en = w_acc && (r_state == HDR) && !w_n_zero;
  assign wr_iter_lim_en  = wr_num_limbs_en;
  assign num_limbs_data  = w_hdr_n;
  assign iter_lim_data   = w_hdr_lim;
  assign wr_real_en      = w_acc && (r_state == LOAD_RE);
  assign wr_imag_en      = w_acc && (r_state == LOAD_IM);
  assign wr_ind          = r_cnt;
  assign limb_data       = job.in_data;
  assign start           = (r_state == START) && !r_res_valid;

  assign job.in_ready  = w_in_ready;
  assign job.res_valid = r_res_valid;
  assign job.res_id    = r_res_id;
  assign job.res_count = r_res_count;
  assign job.res_err   = r_res_err;
  assign jobs_done     = r_jobs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= HDR;
      r_cnt       <= '0;
      r_n         <= '0;
      r_id        <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_count <= '0;
      r_res_err   <= 1'b0;
      r_jobs      <= '0;
    end else begin
      if (w_res_hs) begin
        r_res_valid <= 1'b0;
        r_jobs      <= r_jobs + 16'd1;
      end
      case (r_state)
        HDR: begin
          if (w_acc && w_n_zero) begin
            r_res_valid <= 1'b1;
            r_res_id    <= w_hdr_id;
            r_res_count <= '0;
            r_res_err   <= 1'b1;
          end else if (w_acc) begin
            r_n     <= w_hdr_n;
            r_id    <= w_hdr_id;
            r_cnt   <= '0;
            r_state <= LOAD_RE;
          end
        end
        LOAD_RE: begin
          if (w_acc && w_last) begin
            r_cnt   <= '0;
            r_state <= LOAD_IM;
          end else if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LOAD_IM: begin
          if (w_acc && w_last) begin
            r_cnt   <= '0;
            r_state <= START;
          end else if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        START: begin
          if (!r_res_valid) r_state <= WAIT;
        end
        WAIT: begin
          if (out_ready) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_id;
            r_res_count <= iteration_count;
            r_res_err   <= 1'b0;
            r_state     <= HDR;
          end
        end
        default: r_state <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_solver_feeder.sv
// Directed bench for solver_feeder: loads jobs, checks solver
// strobes, start pulses, result slot, backpressure and async reset.
module tb_solver_feeder;
  logic        clock;
  logic        reset;
  logic        wr_real_en, wr_imag_en;
  logic [5:0]  wr_ind;
  logic [31:0] limb_data;
  logic        wr_num_limbs_en, wr_iter_lim_en;
  logic [5:0]  num_limbs_data;
  logic [15:0] iter_lim_data;
  logic        start;
  logic        out_ready;
  logic [15:0] iteration_count;
  logic [15:0] jobs_done;

  int n_vec = 0;
  int n_err = 0;

  solver_feeder_if #(.LIMB_BITS(32), .ID_BITS(8)) job ();

  solver_feeder #(
    .LIMB_INDEX_BITS(6), .LIMB_BITS(32), .ID_BITS(8)
  ) dut (
    .clock(clock), .reset(reset), .job(job),
    .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en),
    .wr_ind(wr_ind), .limb_data(limb_data),
    .wr_num_limbs_en(wr_num_limbs_en),
    .wr_iter_lim_en(wr_iter_lim_en),
    .num_limbs_data(num_limbs_data),
    .iter_lim_data(iter_lim_data), .start(start),
    .out_ready(out_ready), .iteration_count(iteration_count),
    .jobs_done(jobs_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [31:0] hdr(input int n, input int lim,
                                      input int id);
    return ((32'(id) & 32'hFF) << 22) | ((32'(lim) & 32'hFFFF) << 6)
           | (32'(n) & 32'h3F);
  endfunction

  function automatic logic [31:0] limb(input int n, input int ph,
                                       input int k);
    return 32'h11 * 32'(ph * n + k + 1);
  endfunction

  task automatic load_job(input int n, input int lim, input int id,
                          input int gap);
    job.in_valid = 1'b1;
    job.in_data  = hdr(n, lim, id);
    #1;
    chk("hdr_ready", 32'(job.in_ready), 1);
    chk("hdr_wr_en", {30'd0, wr_num_limbs_en, wr_iter_lim_en}, 3);
    chk("hdr_n", 32'(num_limbs_data), 32'(n));
    chk("hdr_lim", 32'(iter_lim_data), 32'(lim));
    tick();
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < n; k++) begin
        if (gap > 0 && !(ph == 0 && k == 0)) begin
          job.in_valid = 1'b0;
          for (int g = 0; g < gap; g++) begin
            #1;
            chk("gap_strobes", {29'd0, wr_real_en, wr_imag_en,
                                wr_num_limbs_en}, 0);
            tick();
          end
        end
        job.in_valid = 1'b1;
        job.in_data  = limb(n, ph, k);
        #1;
        chk("limb_en", {30'd0, wr_real_en, wr_imag_en},
            (ph == 0) ? 32'd2 : 32'd1);
        chk("limb_ind", 32'(wr_ind), 32'(k));
        chk("limb_data", limb_data, limb(n, ph, k));
        tick();
      end
    end
    job.in_valid = 1'b0;
  endtask

  task automatic finish_job(input logic [15:0] cnt, input int id);
    #1;
    chk("start_pulse", 32'(start), 1);
    chk("start_no_rdy", 32'(job.in_ready), 0);
    tick();
    chk("start_once", 32'(start), 0);
    out_ready       = 1'b1;
    iteration_count = cnt;
    tick();
    out_ready = 1'b0;
    #1;
    chk("res_valid", 32'(job.res_valid), 1);
    chk("res_id", 32'(job.res_id), 32'(id));
    chk("res_count", 32'(job.res_count), 32'(cnt));
    chk("res_err", 32'(job.res_err), 0);
  endtask

  task automatic consume(input int exp_jobs);
    job.res_ready = 1'b1;
    tick();
    job.res_ready = 1'b0;
    #1;
    chk("res_cleared", 32'(job.res_valid), 0);
    chk("jobs_done", 32'(jobs_done), 32'(exp_jobs));
  endtask

  initial begin
    reset           = 1'b0;
    job.in_valid    = 1'b0;
    job.in_data     = '0;
    job.res_ready   = 1'b0;
    out_ready       = 1'b0;
    iteration_count = '0;
    #3;
    chk("rst_res_valid", 32'(job.res_valid), 0);
    chk("rst_res_id", 32'(job.res_id), 0);
    chk("rst_res_count", 32'(job.res_count), 0);
    chk("rst_res_err", 32'(job.res_err), 0);
    chk("rst_jobs", 32'(jobs_done), 0);
    chk("rst_start", 32'(start), 0);
    tick();
    tick();
    reset = 1'b1;

    // basic job, back-to-back limbs
    load_job(2, 100, 8'h5A, 0);
    finish_job(16'd37, 8'h5A);
    consume(1);

    // gaps of 3 idle cycles between limbs
    load_job(2, 5, 8'h21, 3);
    finish_job(16'd9, 8'h21);
    consume(2);

    // result held: job B loads but start stalls
    load_job(1, 10, 8'hA1, 0);
    finish_job(16'd55, 8'hA1);
    load_job(1, 10, 8'hB2, 0);
    #1;
    chk("stall_start", 32'(start), 0);
    chk("stall_count", 32'(job.res_count), 55);
    tick();
    chk("stall_start2", 32'(start), 0);
    chk("stall_id", 32'(job.res_id), 8'hA1);
    job.res_ready = 1'b1;
    tick();
    job.res_ready = 1'b0;
    #1;
    chk("a_consumed", 32'(job.res_valid), 0);
    chk("a_jobs", 32'(jobs_done), 3);
    finish_job(16'd66, 8'hB2);
    consume(4);

    // empty job -> error result
    job.in_valid = 1'b1;
    job.in_data  = hdr(0, 3, 8'h07);
    #1;
    chk("n0_ready", 32'(job.in_ready), 1);
    chk("n0_strobes", {28'd0, wr_num_limbs_en, wr_iter_lim_en,
                       wr_real_en, wr_imag_en}, 0);
    tick();
    job.in_data = hdr(0, 3, 8'h08);
    #1;
    chk("n0_res_valid", 32'(job.res_valid), 1);
    chk("n0_res_id", 32'(job.res_id), 8'h07);
    chk("n0_res_err", 32'(job.res_err), 1);
    chk("n0_res_count", 32'(job.res_count), 0);
    chk("n0_busy_ready", 32'(job.in_ready), 0);
    tick();
    chk("n0_held_id", 32'(job.res_id), 8'h07);
    job.res_ready = 1'b1;
    tick();
    job.res_ready = 1'b0;
    #1;
    chk("n0_jobs", 32'(jobs_done), 5);
    chk("n0_retry_ready", 32'(job.in_ready), 1);
    tick();
    job.in_valid = 1'b0;
    #1;
    chk("n0b_res_id", 32'(job.res_id), 8'h08);
    chk("n0b_res_err", 32'(job.res_err), 1);
    consume(6);

    // iteration limit reached passes through
    load_job(1, 16'hFFFF, 8'h42, 0);
    finish_job(16'hFFFF, 8'h42);

    // async reset mid LOAD_IM with a result still pending
    job.in_valid = 1'b1;
    job.in_data  = hdr(2, 20, 8'h33);
    tick();
    for (int k = 0; k < 3; k++) begin
      job.in_data = 32'h100 + 32'(k);
      tick();
    end
    job.in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_res_valid", 32'(job.res_valid), 0);
    chk("arst_res_count", 32'(job.res_count), 0);
    chk("arst_res_id", 32'(job.res_id), 0);
    chk("arst_jobs", 32'(jobs_done), 0);
    chk("arst_outs", {29'd0, start, job.in_ready, wr_imag_en}, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_start", 32'(start), 0);
    load_job(1, 7, 8'h44, 0);
    finish_job(16'd12, 8'h44);
    consume(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/solver_feeder.md
SOLVER_FEEDER -- requirements
Module: solver_feeder

Interface
REQ-001 SHALL have parameter LIMB_INDEX_BITS, default 6, limb index width; must match solver_control.
REQ-002 SHALL have parameter LIMB_BITS, default 32, width of one limb and of one input word.
REQ-003 SHALL have parameter ID_BITS, default 8, job tag width; LIMB_INDEX_BITS+16+ID_BITS <= LIMB_BITS is required.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-007 in_valid  in  1  job word present.
REQ-008 in_ready  out  1  job word accepted when in_valid && in_ready.
REQ-009 in_data  in  LIMB_BITS  header word or limb word.
REQ-010 wr_real_en, wr_imag_en  out  1 each  c limb write strobes to solver_control.
REQ-011 wr_ind  out  LIMB_INDEX_BITS  limb index for c writes.
REQ-012 limb_data  out  LIMB_BITS  limb value for the c register files.
REQ-013 wr_num_limbs_en, wr_iter_lim_en  out  1 each  parameter write strobes.
REQ-014 num_limbs_data  out  LIMB_INDEX_BITS; iter_lim_data  out  16.
REQ-015 start  out  1  one-cycle solve request.
REQ-016 out_ready  in  1; iteration_count  in  16  solver completion level and result.
REQ-017 res_valid  out  1; res_ready  in  1  result handshake.
REQ-018 res_id  out  ID_BITS; res_count  out  16; res_err  out  1  result payload.
REQ-019 jobs_done  out  16  count of results delivered.

Function
REQ-020 Job format SHALL be a header word, then N real limbs with index 0 first, then N imag limbs with index 0 first; header bits are [LIMB_INDEX_BITS-1:0]=N, the next 16 bits=iteration limit, the next ID_BITS bits=id.
REQ-021 States SHALL be HDR, LOAD_RE, LOAD_IM, START, WAIT.
REQ-022 in_ready SHALL be 1 in HDR, LOAD_RE and LOAD_IM, and 0 in START and WAIT.
REQ-023 Header accept in HDR with N>0: pulse wr_num_limbs_en and wr_iter_lim_en in the same cycle with data taken directly from in_data; latch N and id; clear the limb counter; go to LOAD_RE.
REQ-024 Header accept in HDR with N==0: no solver writes; stay in HDR; queue an error result (id, count 0, res_err=1) using the rules in REQ-030.
REQ-025 Each limb accept SHALL drive the strobe combinationally in the same cycle (zero latency): wr_real_en (LOAD_RE) or wr_imag_en (LOAD_IM), with wr_ind=counter and limb_data=in_data.
REQ-026 The limb counter SHALL increment on each accept; on the accept with counter==N-1 it clears, and the state moves LOAD_RE->LOAD_IM or LOAD_IM->START.
REQ-027 While in_valid is low, the state and counter SHALL hold, and all strobes SHALL be 0.
REQ-028 In START, start SHALL assert for exactly one cycle, and only when res_valid==0; otherwise START holds with start=0; START->WAIT.
REQ-029 In WAIT, out_ready==1 SHALL capture res_count=iteration_count, res_id=latched id, res_err=0, set res_valid and go to HDR; 0xFFFF is passed through unmodified as "limit reached".
REQ-030 An error result (REQ-024) SHALL be taken only when res_valid==0; otherwise in_ready drops and the header is held unaccepted until res_valid clears.
REQ-031 res_valid and its payload SHALL hold stable until a cycle with res_valid && res_ready; that cycle clears res_valid and increments jobs_done, which wraps 0xFFFF->0.
REQ-032 A new header SHALL be accepted while the previous result is still pending; only start and error-result capture wait on the result slot.
REQ-033 Any strobe not named as active in a state SHALL be 0; the data outputs are don't-care when their strobe is 0.

Reset
REQ-034 reset low SHALL set state=HDR, counter=0, res_valid=0, res_id=0, res_count=0, res_err=0 and jobs_done=0, asynchronously.
REQ-035 Reset mid-job SHALL abandon the job with no result; the block never issues start for it.
REQ-036 Reset SHALL deassert synchronously to clock, and the first edge after deassertion SHALL be able to accept a header.

Verification
REQ-037 Header N=2, limit=100, id=0x5A, then real 0x11,0x22 and imag 0x33,0x44 streamed back-to-back -> wr_real_en at wr_ind 0,1; wr_imag_en at wr_ind 0,1; start one cycle later; out_ready with count 37 -> res_valid, res_id=0x5A, res_count=37, res_err=0.
REQ-038 Insert in_valid gaps of 3 cycles between limbs -> no strobes during the gaps, and the same four writes occur.
REQ-039 Hold res_ready=0, complete job A, stream job B fully -> B loads, START stalls with start=0, res_count stays at A's value; raise res_ready -> A is consumed, jobs_done=1, then B's start pulses.
REQ-040 Header with N=0, id=0x07 -> no solver strobes, res_valid, res_id=0x07, res_err=1, res_count=0.
REQ-041 Drive reset low in LOAD_IM after 1 of 2 imag limbs -> all outputs reach their reset values without waiting for a clock edge; no start; the next header is accepted normally.
REQ-042 Solver returns iteration_count=0xFFFF -> res_count=0xFFFF and res_err=0.
